// File: rtl/mem_arbiter.sv
// Main-memory arbiter: shares even/odd byte banks between the CPU and one DMA port.
// CPU has priority, a starvation guard lets DMA through, and every access runs IDLE -> ACC -> RESP.
module mem_arbiter #(
    parameter int ADRS_W     = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_wbyte,
    input  logic [15:0]       cpu_adrs,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [15:0]       dma_adrs,
    input  logic [15:0]       dma_wdata,
    output logic [15:0]       dma_rdata,
    output logic              dma_ack,
    output logic [ADRS_W-1:0] mem_adrs,
    output logic              mem_we_e,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_e,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_e,
    input  logic [7:0]        mem_rdata_o,
    output logic [1:0]        fsm_state
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     starve_cnt;
    logic              own_dma;
    logic              rd_q;
    logic              we_e_q;
    logic              we_o_q;

    logic              grant_dma;
    logic              win_we;
    logic              win_wbyte;
    logic [15:0]       win_adrs;
    logic [15:0]       win_wdata;
    logic [ADRS_W-1:0] win_word;
    logic              unused_adrs;

    // Winner selection; DMA is word-only, so its bit0 is forced low and wbyte never applies.
    always_comb begin
        grant_dma = dma_req && (!cpu_req || (starve_cnt == STARVE_LIM));
        win_we    = grant_dma ? dma_we : cpu_we;
        win_wbyte = grant_dma ? 1'b0 : (cpu_we && cpu_wbyte);
        win_adrs  = grant_dma ? {dma_adrs[15:1], 1'b0} : cpu_adrs;
        win_wdata = grant_dma ? dma_wdata : cpu_wdata;
    end

    // Address bits above the bank range are dropped, so addresses wrap.
    assign win_word    = win_adrs[ADRS_W:1];
    assign unused_adrs = ^{win_adrs[15:ADRS_W+1], dma_adrs[0]};

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            own_dma     <= 1'b0;
            rd_q        <= 1'b0;
            we_e_q      <= 1'b0;
            we_o_q      <= 1'b0;
            mem_adrs    <= '0;
            mem_wdata_e <= '0;
            mem_wdata_o <= '0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!dma_req || grant_dma) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_LIM) begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                    if (cpu_req || dma_req) begin
                        own_dma     <= grant_dma;
                        rd_q        <= !win_we;
                        mem_adrs    <= win_word;
                        we_e_q      <= win_we && !(win_wbyte && win_adrs[0]);
                        we_o_q      <= win_we && !(win_wbyte && !win_adrs[0]);
                        mem_wdata_e <= win_wbyte ? win_wdata[7:0] : win_wdata[15:8];
                        mem_wdata_o <= win_wdata[7:0];
                        state       <= ACC;
                    end
                end
                ACC: begin
                    we_e_q  <= 1'b0;
                    we_o_q  <= 1'b0;
                    cpu_ack <= !own_dma;
                    dma_ack <= own_dma;
                    state   <= RESP;
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    if (rd_q) begin
                        if (own_dma) begin
                            dma_rdata <= {mem_rdata_e, mem_rdata_o};
                        end else begin
                            cpu_rdata <= {mem_rdata_e, mem_rdata_o};
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset sampled at the end of ACC must not let the pending write land on that same edge.
    assign mem_we_e  = we_e_q && !p_reset;
    assign mem_we_o  = we_o_q && !p_reset;
    assign fsm_state = state;

endmodule
